display_scan_ctrl: RTL and testbench

//  Time-multiplexing scheduler for the 4-digit 7-segment panel of the irrigation controller.

---
 rtl/display_pkg.sv | 22 ++
 rtl/scan_slot_timer.sv | 50 +++++
 rtl/display_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_display_scan_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the 7-segment panel scan controller.
package display_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] DIG_OFF_N  = 4'hF;

  typedef logic [1:0] digit_sel_t;

  typedef enum logic [1:0] {
    BLANK,
    SHOW,
    OFF
  } scan_state_t;

  // Active-low enable pattern with only the selected digit driven low.
  function automatic logic [3:0] dig_decode(input digit_sel_t s);
    logic [3:0] onehot;
    onehot = 4'b0001 << s;
    return ~onehot;
  endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// Per-digit slot counter. The flags describe the slot cycle that k takes on
// at the coming clock edge, so the owner can register outputs aligned with it.
module scan_slot_timer #(
  parameter int PRESCALE     = 8,
  parameter int BLANK_CYCLES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic slot_start_o,
  output logic slot_last_o,
  output logic in_show_o
);

  localparam int             K_W    = $clog2(PRESCALE);
  localparam logic [K_W-1:0] K_LAST = K_W'(PRESCALE - 1);

  logic [K_W-1:0] k_q;
  logic [K_W-1:0] k_d;

  always_comb begin
    k_d = k_q;
    if (clr_i) begin
      k_d = '0;
    end else if (en_i) begin
      k_d = (k_q == K_LAST) ? '0 : k_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      k_q <= '0;
    end else begin
      k_q <= k_d;
    end
  end

  assign slot_start_o = (k_d == '0);
  assign slot_last_o  = (k_d == K_LAST);

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_show_o = 1'b1;
    end else begin : g_blank
      assign in_show_o = (k_d >= K_W'(BLANK_CYCLES));
    end
  endgenerate

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan scheduler for the 4-digit 7-segment panel, with blanking dead-time.
// Define DISPLAY_ALERT_BLINK_EN to blink the ALERT_DIGIT image while the low-tank alert is active.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int PRESCALE     = 8,
  parameter int BLANK_CYCLES = 2,
  parameter int BLINK_FRAMES = 2,
  parameter int ALERT_DIGIT  = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       scan_en,
  input  logic       alert,
  output logic [1:0] sel,
  output logic [3:0] dig_n,
  output logic       blank,
  output logic       frame_tick
);

  localparam digit_sel_t LAST_SEL = digit_sel_t'(NUM_DIGITS - 1);

  scan_state_t state_q, state_d;
  digit_sel_t  sel_q, sel_d;
  logic [3:0]  dig_n_q, dig_n_d;
  logic        blank_q, blank_d;
  logic        tick_q, tick_d;

  logic        slot_start, slot_last, in_show;
  logic        timer_clr, sel_adv, supp_d;

  // Leaving or sitting in OFF always restarts the held digit at slot cycle 0.
  assign timer_clr = !scan_en || (state_q == OFF);

  scan_slot_timer #(
    .PRESCALE    (PRESCALE),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_slot_timer (
    .clk_i       (CLK),
    .rst_i       (RST),
    .en_i        (scan_en),
    .clr_i       (timer_clr),
    .slot_start_o(slot_start),
    .slot_last_o (slot_last),
    .in_show_o   (in_show)
  );

  // sel only moves on a slot wrap, which is always a blanking edge.
  assign sel_adv = scan_en && (state_q != OFF) && slot_start;
  assign sel_d   = sel_adv ? ((sel_q == LAST_SEL) ? '0 : sel_q + 1'b1) : sel_q;
  assign tick_d  = scan_en && slot_last && (sel_d == LAST_SEL);

  always_comb begin
    state_d = BLANK;
    dig_n_d = DIG_OFF_N;
    blank_d = 1'b1;
    if (!scan_en) begin
      state_d = OFF;
    end else if (in_show) begin
      state_d = SHOW;
    end
    if ((state_d == SHOW) && !supp_d) begin
      dig_n_d = dig_decode(sel_d);
      blank_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= BLANK;
      sel_q   <= '0;
      dig_n_q <= DIG_OFF_N;
      blank_q <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      dig_n_q <= dig_n_d;
      blank_q <= blank_d;
      tick_q  <= tick_d;
    end
  end

`ifdef DISPLAY_ALERT_BLINK_EN
  localparam int              FC_W      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST   = FC_W'(BLINK_FRAMES - 1);
  localparam digit_sel_t      ALERT_SEL = digit_sel_t'(ALERT_DIGIT);

  logic [FC_W-1:0] fc_q, fc_d;
  logic            phase_q, phase_d;
  logic            supp_q;

  // The suppress decision is latched at slot start and held for the whole slot.
  always_comb begin
    fc_d    = fc_q;
    phase_d = phase_q;
    supp_d  = supp_q;
    if (tick_d) begin
      if (fc_q == FC_LAST) begin
        fc_d    = '0;
        phase_d = !phase_q;
      end else begin
        fc_d = fc_q + 1'b1;
      end
    end
    if (scan_en && slot_start) begin
      supp_d = (sel_d == ALERT_SEL) && alert && phase_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fc_q    <= '0;
      phase_q <= 1'b0;
      supp_q  <= 1'b0;
    end else begin
      fc_q    <= fc_d;
      phase_q <= phase_d;
      supp_q  <= supp_d;
    end
  end
`else
  logic unused_blink_cfg;

  assign supp_d           = 1'b0;
  assign unused_blink_cfg = alert ^ (ALERT_DIGIT == BLINK_FRAMES);
`endif

  assign sel        = sel_q;
  assign dig_n      = dig_n_q;
  assign blank      = blank_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: directed literal scenarios followed by random scan_en/alert/reset
// traffic, all checked every cycle against a slot-position model of the panel.
module tb_display_scan_ctrl;

  localparam int P  = 8;
  localparam int B  = 2;
  localparam int BF = 2;
  localparam int AD = 0;
`ifdef DISPLAY_ALERT_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic       scan_en;
  logic       alert;
  logic [1:0] sel;
  logic [3:0] dig_n;
  logic       blank;
  logic       frame_tick;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;
  int idx = 0;
  int ntick;

  // model state: panel position p = sel*P + k, frames completed since reset
  int         m_p = 0;
  int         m_frames = 0;
  bit         m_dark = 1'b0;
  bit         m_supp = 1'b0;
  logic [3:0] exp_dig = 4'hF;
  logic [1:0] exp_sel = 2'd0;
  logic       exp_blank = 1'b1;
  logic       exp_tick = 1'b0;

  display_scan_ctrl #(
    .PRESCALE    (P),
    .BLANK_CYCLES(B),
    .BLINK_FRAMES(BF),
    .ALERT_DIGIT (AD)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .scan_en   (scan_en),
    .alert     (alert),
    .sel       (sel),
    .dig_n     (dig_n),
    .blank     (blank),
    .frame_tick(frame_tick)
  );

  always #5 CLK = ~CLK;

  initial begin : model_p
    bit start;
    bit show;
    int k;
    int s;
    forever begin
      @(posedge CLK);
      start = 1'b0;
      if (RST) begin
        m_p      = 0;
        m_frames = 0;
        m_dark   = 1'b0;
        m_supp   = 1'b0;
        exp_tick = 1'b0;
      end else begin
        exp_tick = 1'b0;
        if (!scan_en) begin
          m_p    = (m_p / P) * P;
          m_dark = 1'b1;
        end else if (m_dark) begin
          m_dark = 1'b0;
          start  = 1'b1;
        end else begin
          m_p      = (m_p + 1) % (4 * P);
          start    = ((m_p % P) == 0);
          exp_tick = (m_p == 4 * P - 1);
        end
        if (exp_tick) m_frames++;
        if (start) m_supp = BLINK_EN && ((m_p / P) == AD) && alert && (((m_frames / BF) % 2) == 1);
      end
      k         = m_p % P;
      s         = m_p / P;
      show      = !RST && !m_dark && (k >= B) && !m_supp;
      exp_dig   = show ? ~(4'b0001 << s) : 4'hF;
      exp_blank = !show;
      exp_sel   = 2'(s);
    end
  end

  initial begin : compare_p
    forever begin
      @(negedge CLK);
      if (chk_en) begin
        n_checks++;
        if (dig_n !== exp_dig || blank !== exp_blank || sel !== exp_sel || frame_tick !== exp_tick) begin
          n_errors++;
          $display("FAIL model t=%0t: dig_n=%b blank=%b sel=%0d tick=%b, expected dig_n=%b blank=%b sel=%0d tick=%b",
                   $time, dig_n, blank, sel, frame_tick, exp_dig, exp_blank, exp_sel, exp_tick);
        end
        n_checks++;
        if ($countones(~dig_n) > 1 || blank !== (dig_n == 4'hF)) begin
          n_errors++;
          $display("FAIL onehot t=%0t: dig_n=%b blank=%b, required at most one low bit and blank=(dig_n==F)",
                   $time, dig_n, blank);
        end
      end
    end
  end

  task automatic step();
    @(negedge CLK);
    idx++;
  endtask

  task automatic run_to(input int target);
    while (idx < target) step();
  endtask

  task automatic lit(input string nm, input logic [3:0] d, input logic [1:0] s, input logic t);
    n_checks++;
    if (dig_n !== d || sel !== s || frame_tick !== t || blank !== (d == 4'hF)) begin
      n_errors++;
      $display("FAIL %s idx=%0d: dig_n=%b sel=%0d tick=%b blank=%b, expected dig_n=%b sel=%0d tick=%b",
               nm, idx, dig_n, sel, frame_tick, blank, d, s, t);
    end
  endtask

  initial begin : stim_p
    RST     = 1'b1;
    scan_en = 1'b1;
    alert   = 1'b0;
    repeat (3) @(negedge CLK);
    chk_en = 1'b1;
    lit("reset_vals", 4'hF, 2'd0, 1'b0);

    // power-up free run, cycle 0 is the first cycle after reset
    RST   = 1'b0;
    idx   = 0;
    ntick = 0;
    for (int i = 0; i < 100; i++) begin
      if (i > 0) step();
      if (frame_tick === 1'b1) ntick++;
      case (idx)
        0:  lit("run_k0",    4'hF,    2'd0, 1'b0);
        1:  lit("run_k1",    4'hF,    2'd0, 1'b0);
        2:  lit("run_d0_on", 4'b1110, 2'd0, 1'b0);
        7:  lit("run_d0_end",4'b1110, 2'd0, 1'b0);
        8:  lit("run_s1_blk",4'hF,    2'd1, 1'b0);
        10: lit("run_d1_on", 4'b1101, 2'd1, 1'b0);
        18: lit("run_d2_on", 4'b1011, 2'd2, 1'b0);
        26: lit("run_d3_on", 4'b0111, 2'd3, 1'b0);
        30: lit("run_c30",   4'b0111, 2'd3, 1'b0);
        31: lit("tick_31",   4'b0111, 2'd3, 1'b1);
        32: lit("wrap_32",   4'hF,    2'd0, 1'b0);
        63: lit("tick_63",   4'b0111, 2'd3, 1'b1);
        64: lit("wrap_64",   4'hF,    2'd0, 1'b0);
        95: lit("tick_95",   4'b0111, 2'd3, 1'b1);
        default: ;
      endcase
    end
    n_checks++;
    if (ntick != 3) begin
      n_errors++;
      $display("FAIL tick_count: %0d frame ticks in 100 cycles, expected 3", ntick);
    end

    // scan_en drop in slot 1 at k=5, resume after 10 cycles
    run_to(109);
    lit("pre_off", 4'b1101, 2'd1, 1'b0);
    scan_en = 1'b0;
    step();
    lit("off_next", 4'hF, 2'd1, 1'b0);
    run_to(115);
    lit("off_hold", 4'hF, 2'd1, 1'b0);
    run_to(119);
    scan_en = 1'b1;
    step();
    lit("resume_k0", 4'hF, 2'd1, 1'b0);
    step();
    lit("resume_k1", 4'hF, 2'd1, 1'b0);
    step();
    lit("resume_on", 4'b1101, 2'd1, 1'b0);
    run_to(127);
    lit("resume_end", 4'b1101, 2'd1, 1'b0);
    step();
    lit("resume_next", 4'hF, 2'd2, 1'b0);

    // reset during slot 2 SHOW
    run_to(132);
    lit("pre_rst", 4'b1011, 2'd2, 1'b0);
    RST = 1'b1;
    step();
    lit("rst_mid", 4'hF, 2'd0, 1'b0);
    RST = 1'b0;
    idx = 0;
    step();
    lit("rerun_k1", 4'hF, 2'd0, 1'b0);
    step();
    lit("rerun_on", 4'b1110, 2'd0, 1'b0);

    // alert rises mid-slot in frame 2, then stays high
    run_to(66);
    lit("blk_f2_pre", 4'b1110, 2'd0, 1'b0);
    run_to(68);
    alert = 1'b1;
    step();
    lit("blk_f2_k5", 4'b1110, 2'd0, 1'b0);
    run_to(71);
    lit("blk_f2_k7", 4'b1110, 2'd0, 1'b0);
    run_to(98);
    lit("blk_f3_d0", BLINK_EN ? 4'hF : 4'b1110, 2'd0, 1'b0);
    run_to(106);
    lit("blk_f3_d1", 4'b1101, 2'd1, 1'b0);
    run_to(130);
    lit("blk_f4_d0", 4'b1110, 2'd0, 1'b0);
    run_to(194);
    lit("blk_f6_d0", BLINK_EN ? 4'hF : 4'b1110, 2'd0, 1'b0);
    run_to(202);
    lit("blk_f6_d1", 4'b1101, 2'd1, 1'b0);
    run_to(226);
    lit("blk_f7_d0", BLINK_EN ? 4'hF : 4'b1110, 2'd0, 1'b0);
    run_to(258);
    lit("blk_f8_d0", 4'b1110, 2'd0, 1'b0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      step();
      if (RST) RST = 1'b0;
      else if ($urandom_range(0, 1499) == 0) RST = 1'b1;
      if (scan_en) scan_en = ($urandom_range(0, 49) != 0);
      else scan_en = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 29) == 0) alert = !alert;
    end
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
